band_write_ctrl: RTL

Sequences coefficient-gain writes into the 8-band parametric equalizer.
- Accepts band/gain commands over a valid/ready handshake.
- Holds each write until the next audio sample boundary so band coefficients never change mid-sample.
- Drives the 3-bit band select and a one-cycle write strobe into the 1-to-8 band-enable demultiplexer, plus a shared gain bus for all band registers.

---
 rtl/eq_pkg.sv | 24 ++
 rtl/gain_clamp.sv | 30 +++
 rtl/band_write_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Shared types and constants for the 8-band parametric equalizer control path.
//   BAND_W / NUM_BANDS : band select width and band count
//   GAIN_W_DEF         : default signed gain word width
//   gain_t             : signed gain word at the default width
//   band_wr_state_t    : band write sequencer states
// ---------------------------------------------------------------------------
package eq_pkg;

    localparam int BAND_W     = 3;
    localparam int NUM_BANDS  = 8;
    localparam int GAIN_W_DEF = 16;

    typedef logic signed [GAIN_W_DEF-1:0] gain_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        STROBE,
        SETTLE
    } band_wr_state_t;

endpackage

// File: rtl/gain_clamp.sv
// ---------------------------------------------------------------------------
// gain_clamp
// Combinational signed saturator: limits a gain word to [-GAIN_LIMIT, +GAIN_LIMIT].
// Ports:
//   gain_i : raw signed gain
//   gain_o : saturated signed gain
//   sat_o  : high when gain_i was outside the limit
// ---------------------------------------------------------------------------
module gain_clamp #(
    parameter int                        GAIN_W     = 16,
    parameter logic signed [GAIN_W-1:0]  GAIN_LIMIT = 16'sd12288
) (
    input  logic signed [GAIN_W-1:0] gain_i,
    output logic signed [GAIN_W-1:0] gain_o,
    output logic                     sat_o
);

    always_comb begin
        gain_o = gain_i;
        sat_o  = 1'b0;
        if (gain_i > GAIN_LIMIT) begin
            gain_o = GAIN_LIMIT;
            sat_o  = 1'b1;
        end else if (gain_i < -GAIN_LIMIT) begin
            gain_o = -GAIN_LIMIT;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/band_write_ctrl.sv
// ---------------------------------------------------------------------------
// band_write_ctrl
// Sequences band gain writes into the equalizer. A command is captured on
// handshake, held until the next sample_tick, then issued as a one-cycle
// write strobe to the 1-to-8 band-enable demux, followed by a settle gap.
//
// Optional feature macro: GAIN_CLAMP_EN (saturate captured gain to
// +/-GAIN_LIMIT and pulse 'clamped'); when undefined gain passes unchanged.
//
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   sample_tick             : one-cycle pulse at each audio sample boundary
//   cmd_valid/cmd_ready     : command handshake (ready = state IDLE)
//   cmd_band, cmd_gain      : target band and signed gain
//   select, gain_out        : band select and shared gain bus (registered)
//   wr_strobe, wr_done      : write pulse and its one-cycle-later completion
//   timeout_err             : sticky, command dropped for lack of tick
//   clamped                 : one-cycle pulse when captured gain saturated
// ---------------------------------------------------------------------------
module band_write_ctrl
    import eq_pkg::*;
#(
    parameter int                       GAIN_W        = GAIN_W_DEF,
    parameter int                       SETTLE_CYCLES = 2,
    parameter int                       TICK_TIMEOUT  = 1024,
    parameter logic signed [GAIN_W-1:0] GAIN_LIMIT    = 16'sd12288
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BAND_W-1:0] cmd_band,
    input  logic [GAIN_W-1:0] cmd_gain,
    output logic [BAND_W-1:0] select,
    output logic              wr_strobe,
    output logic [GAIN_W-1:0] gain_out,
    output logic              wr_done,
    output logic              timeout_err,
    output logic              clamped
);

    // One counter serves both the tick wait and the settle gap; it is sized
    // for the larger of the two terminal counts.
    localparam int CNT_MAX = (TICK_TIMEOUT > SETTLE_CYCLES) ? TICK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TICK_TIMEOUT  > 0) ? TICK_TIMEOUT  - 1 : 0);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    band_wr_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [BAND_W-1:0] select_q, select_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              strobe_q, strobe_d;
    logic              done_q;
    logic              clamped_q, clamped_d;
    logic              terr_q, terr_d;

    logic [GAIN_W-1:0] gain_cap;
    logic              gain_sat;

`ifdef GAIN_CLAMP_EN
    gain_clamp #(
        .GAIN_W     (GAIN_W),
        .GAIN_LIMIT (GAIN_LIMIT)
    ) u_gain_clamp (
        .gain_i (cmd_gain),
        .gain_o (gain_cap),
        .sat_o  (gain_sat)
    );
`else
    logic unused_limit;
    assign unused_limit = ^GAIN_LIMIT;
    assign gain_cap     = cmd_gain;
    assign gain_sat     = 1'b0;
`endif

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        select_d  = select_q;
        gain_d    = gain_q;
        strobe_d  = 1'b0;
        clamped_d = 1'b0;
        terr_d    = terr_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    select_d  = cmd_band;
                    gain_d    = gain_cap;
                    clamped_d = gain_sat;
                    cnt_d     = '0;
                    state_d   = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                // Tick has priority over a timeout landing on the same cycle.
                if (sample_tick) begin
                    strobe_d = 1'b1;
                    state_d  = STROBE;
                end else if ((TICK_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STROBE: begin
                cnt_d   = '0;
                state_d = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
            end
            SETTLE: begin
                if (cnt_q == ST_LAST) state_d = IDLE;
                else                  cnt_d   = cnt_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            select_q  <= '0;
            gain_q    <= '0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            select_q  <= select_d;
            gain_q    <= gain_d;
            strobe_q  <= strobe_d;
            done_q    <= strobe_q;
            clamped_q <= clamped_d;
            terr_q    <= terr_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign select      = select_q;
    assign gain_out    = gain_q;
    assign wr_strobe   = strobe_q;
    assign wr_done     = done_q;
    assign clamped     = clamped_q;
    assign timeout_err = terr_q;

endmodule
